// File: rtl/axis_sample_pkg.sv
// Shared constants for the sample packetizer: FSM encodings and counter limits.
package axis_sample_pkg;
  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  RUN     = 2'd1;
  localparam logic [1:0]  PAD     = 2'd2;
  localparam logic [15:0] OVF_MAX = 16'hFFFF;
endpackage

// File: rtl/axis_sample_fifo.sv
// First-word-fall-through FIFO with registered storage; the head word is
// visible on rd_data whenever empty is low, and reads as zero otherwise.
module axis_sample_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/axis_sample_packetizer.sv
// Frames the decimated sample stream into fixed-length AXI4-Stream packets,
// zero-padding an open packet on disable and counting drops and packets.
module axis_sample_packetizer
  import axis_sample_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  packet_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_valid,
  output logic                  in_data_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           overflow_cnt,
  output logic [31:0]           packet_cnt
);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 in_data_ready_q, in_data_ready_d;
  logic [15:0]          overflow_cnt_q, overflow_cnt_d;
  logic [31:0]          packet_cnt_q, packet_cnt_d;

  logic                  fifo_full, fifo_empty;
  logic                  accept, drop, pad_wr, wr_en, wr_last, pop;
  logic [DATA_WIDTH:0]   wr_data, rd_data;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    overflow_cnt_d = overflow_cnt_q;
    packet_cnt_d   = packet_cnt_q;

    accept  = (state_q == RUN) && !fifo_full && in_data_valid;
    drop    = (state_q == RUN) && fifo_full && in_data_valid;
    pad_wr  = (state_q == PAD) && !fifo_full;
    wr_en   = accept || pad_wr;
    wr_last = (cnt_q == len_q - LEN_WIDTH'(1));
    wr_data = {wr_last, in_data};
    if (pad_wr) wr_data = {wr_last, {DATA_WIDTH{1'b0}}};
    pop     = !fifo_empty && m_axis_tready;

    if (wr_en) cnt_d = wr_last ? '0 : cnt_q + LEN_WIDTH'(1);

    // Leaving RUN looks at the post-write counter, so a tlast written in the
    // disabling cycle closes the packet without padding.
    case (state_q)
      IDLE: if (enable) begin
        state_d = RUN;
        len_d   = (packet_len == '0) ? LEN_WIDTH'(1) : packet_len;
        cnt_d   = '0;
      end
      RUN:     if (!enable) state_d = (cnt_d == '0) ? IDLE : PAD;
      PAD:     if (pad_wr && wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    occ_d           = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
    in_data_ready_d = (state_d == RUN) && (occ_d != OCC_W'(FIFO_DEPTH));

    if (drop && overflow_cnt_q != OVF_MAX) overflow_cnt_d = overflow_cnt_q + 16'd1;
    if (pop && rd_data[DATA_WIDTH])        packet_cnt_d   = packet_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      len_q           <= '0;
      cnt_q           <= '0;
      occ_q           <= '0;
      in_data_ready_q <= 1'b0;
      overflow_cnt_q  <= '0;
      packet_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      occ_q           <= occ_d;
      in_data_ready_q <= in_data_ready_d;
      overflow_cnt_q  <= overflow_cnt_d;
      packet_cnt_q    <= packet_cnt_d;
    end
  end

  axis_sample_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (m_axis_tready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_data_ready = in_data_ready_q;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = rd_data[DATA_WIDTH-1:0];
  assign m_axis_tlast  = rd_data[DATA_WIDTH];
  assign overflow_cnt  = overflow_cnt_q;
  assign packet_cnt    = packet_cnt_q;
endmodule

// File: tb/tb_axis_sample_packetizer.sv
// Directed bench for axis_sample_packetizer: framing, backpressure/drop,
// padding on disable, boundary disable, zero length, and mid-stream reset.
module tb_axis_sample_packetizer;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst, enable, in_data_valid, in_data_ready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [LW-1:0] packet_len;
  logic [DW-1:0] in_data, m_axis_tdata;
  logic [15:0]   overflow_cnt;
  logic [31:0]   packet_cnt;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [DW:0]   beats[$];

  always #5 clk = ~clk;

  axis_sample_packetizer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (16),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .packet_len    (packet_len),
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .in_data_ready (in_data_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .overflow_cnt  (overflow_cnt),
    .packet_cnt    (packet_cnt)
  );

  // Inputs change just after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    beats.delete();
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic hs;
    hs = 1'b0;
    in_data       = d;
    in_data_valid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = in_data_ready;
      step();
    end
    chk($sformatf("send_hs_%0h", d), 32'(hs), 32'd1);
  endtask

  task automatic chk_beat(input string tag, input int unsigned i, input logic last,
                          input logic [DW-1:0] d);
    logic [DW:0] got;
    got = (i < beats.size()) ? beats[i] : 'x;
    chk($sformatf("%s_beat%0d", tag, i), 32'(got), 32'({last, d}));
  endtask

  initial begin
    automatic int unsigned acc = 0;
    rst = 1'b1; enable = 1'b0; packet_len = '0; in_data = '0;
    in_data_valid = 1'b0; m_axis_tready = 1'b0;
    step(2);
    chk("rst_ready",  32'(in_data_ready), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_ovf",    32'(overflow_cnt),  32'd0);
    chk("rst_pkt",    packet_cnt,         32'd0);
    rst = 1'b0;
    beats.delete();

    // Framing: len 4, samples 1..8
    packet_len = 16'd4; m_axis_tready = 1'b1; enable = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) send(DW'(k));
    in_data_valid = 1'b0;
    step(4);
    chk("frm_n", beats.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk_beat("frm", i, (i % 4) == 3, DW'(i + 1));
    chk("frm_pkt", packet_cnt, 32'd2);
    chk("frm_ovf", 32'(overflow_cnt), 32'd0);
    enable = 1'b0;
    step(2);
    chk("frm_idle", 32'(dut.state_q), 32'd0);
    chk("frm_ready", 32'(in_data_ready), 32'd0);

    // Backpressure and drop: len 64, 20 samples into a 16-deep FIFO
    do_reset();
    packet_len = 16'd64; m_axis_tready = 1'b0; enable = 1'b1;
    step();
    for (int k = 1; k <= 20; k++) begin
      in_data = DW'(k); in_data_valid = 1'b1;
      if (in_data_ready) acc++;
      step();
    end
    in_data_valid = 1'b0;
    chk("bp_accepts", acc, 32'd16);
    chk("bp_ready",   32'(in_data_ready), 32'd0);
    chk("bp_ovf",     32'(overflow_cnt),  32'd4);
    chk("bp_tvalid",  32'(m_axis_tvalid), 32'd1);
    step(3);
    chk("bp_hold", 32'({m_axis_tlast, m_axis_tdata}), 32'd1);
    m_axis_tready = 1'b1;
    step(20);
    chk("bp_n", beats.size(), 32'd16);
    for (int i = 0; i < 16; i++) chk_beat("bp", i, 1'b0, DW'(i + 1));
    chk("bp_pkt0", packet_cnt, 32'd0);
    beats.delete();
    enable = 1'b0;
    step(60);
    chk("bp_pad_n", beats.size(), 32'd48);
    chk_beat("bp_pad", 47, 1'b1, '0);
    chk_beat("bp_pad", 46, 1'b0, '0);
    chk("bp_pkt1", packet_cnt, 32'd1);

    // Disable mid-packet: len 8, A B C then zero padding
    do_reset();
    packet_len = 16'd8; enable = 1'b1;
    step();
    send(16'hA); send(16'hB); send(16'hC);
    in_data_valid = 1'b0; enable = 1'b0;
    step(12);
    chk("pad_n", beats.size(), 32'd8);
    chk_beat("pad", 0, 1'b0, 16'hA);
    chk_beat("pad", 1, 1'b0, 16'hB);
    chk_beat("pad", 2, 1'b0, 16'hC);
    for (int i = 3; i < 8; i++) chk_beat("pad", i, i == 7, '0);
    chk("pad_idle", 32'(dut.state_q), 32'd0);
    chk("pad_pkt", packet_cnt, 32'd1);

    // Disable on the cycle the closing word is accepted
    do_reset();
    packet_len = 16'd2; enable = 1'b1;
    step();
    send(16'h11);
    in_data = 16'h12; in_data_valid = 1'b1; enable = 1'b0;
    chk("bnd_ready_pre", 32'(in_data_ready), 32'd1);
    step();
    in_data_valid = 1'b0;
    chk("bnd_idle", 32'(dut.state_q), 32'd0);
    chk("bnd_ready", 32'(in_data_ready), 32'd0);
    step(4);
    chk("bnd_n", beats.size(), 32'd2);
    chk_beat("bnd", 0, 1'b0, 16'h11);
    chk_beat("bnd", 1, 1'b1, 16'h12);
    chk("bnd_pkt", packet_cnt, 32'd1);

    // Zero length means one; packet_len changes only take effect on IDLE->RUN
    do_reset();
    packet_len = 16'd0; enable = 1'b1;
    step();
    send(16'd1); send(16'd2); send(16'd3);
    packet_len = 16'd5;
    send(16'd4); send(16'd5); send(16'd6);
    in_data_valid = 1'b0;
    step(3);
    chk("zl_n", beats.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk_beat("zl", i, 1'b1, DW'(i + 1));
    chk("zl_pkt", packet_cnt, 32'd6);
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step();
    for (int k = 7; k <= 11; k++) send(DW'(k));
    in_data_valid = 1'b0;
    step(3);
    chk("zl_n2", beats.size(), 32'd11);
    for (int i = 6; i < 11; i++) chk_beat("zl", i, i == 10, DW'(i + 1));
    chk("zl_pkt2", packet_cnt, 32'd7);

    // Reset with five words buffered
    beats.delete();
    m_axis_tready = 1'b0; packet_len = 16'd8;
    for (int k = 0; k < 5; k++) send(DW'(16'h31 + k));
    in_data_valid = 1'b0;
    chk("mr_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
    chk("mr_pkt_pre", packet_cnt, 32'd7);
    enable = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mr_tlast",  32'(m_axis_tlast),  32'd0);
    chk("mr_tdata",  32'(m_axis_tdata),  32'd0);
    chk("mr_ovf",    32'(overflow_cnt),  32'd0);
    chk("mr_pkt",    packet_cnt,         32'd0);
    chk("mr_ready",  32'(in_data_ready), 32'd0);
    m_axis_tready = 1'b1; enable = 1'b1;
    step();
    for (int k = 0; k < 8; k++) send(DW'(16'h21 + k));
    in_data_valid = 1'b0;
    step(4);
    chk("mr_n", beats.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk_beat("mr", i, i == 7, DW'(16'h21 + i));
    chk("mr_pkt1", packet_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
